// File: rtl/iob_ila_capture.sv
// iob_ila_capture: multi-channel ILA capture core.
// Samples N_CH channels into one circular buffer of 2^BUFFER_W entries,
// keeps a programmable pre-trigger window and offers registered readout
// by index (0 = oldest) and channel.
// Optional feature macro: IOB_ILA_CAPTURE_TIMESTAMP_EN stores a free-running
// TS_W-bit timestamp with every sample, readable on channel N_CH.
module iob_ila_capture #(
    parameter int N_CH      = 4,
    parameter int SIGNAL_W  = 32,
    parameter int BUFFER_W  = 10,
    parameter int TRIGGER_W = 8,
    parameter int TS_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic [N_CH*SIGNAL_W-1:0] signal_i,
    input  logic [TRIGGER_W-1:0]     trigger_i,
    input  logic [TRIGGER_W-1:0]     trigger_type_i,
    input  logic [TRIGGER_W-1:0]     trigger_negate_i,
    input  logic [TRIGGER_W-1:0]     trigger_mask_i,
    input  logic                     trigger_mode_i,
    input  logic [BUFFER_W-1:0]      pretrigger_i,
    input  logic                     arm_i,
    input  logic                     abort_i,
    output logic [1:0]               state_o,
    output logic                     triggered_o,
    output logic [BUFFER_W:0]        n_samples_o,
    output logic [BUFFER_W-1:0]      trig_index_o,
    input  logic                     rd_en_i,
    input  logic [BUFFER_W-1:0]      rd_index_i,
    input  logic [4:0]               rd_ch_i,
    output logic [SIGNAL_W-1:0]      rd_data_o,
    output logic                     rd_valid_o
);

    localparam int D = 1 << BUFFER_W;
`ifdef IOB_ILA_CAPTURE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int TS_STORE_W = TS_EN ? TS_W : 0;
    localparam int ROW_W      = N_CH*SIGNAL_W + TS_STORE_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [BUFFER_W:0]   FULL    = (BUFFER_W+1)'(D);
    localparam logic [BUFFER_W-1:0] ALL_ONE = {BUFFER_W{1'b1}};

    logic [1:0]           state_q, state_d;
    logic [BUFFER_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BUFFER_W:0]    fill_q, fill_d;
    logic [BUFFER_W-1:0]  pre_q, pre_d;
    logic [BUFFER_W-1:0]  post_left_q, post_left_d;
    logic [BUFFER_W-1:0]  start_q, start_d;
    logic                 triggered_q, triggered_d;
    logic [BUFFER_W:0]    n_samples_q, n_samples_d;
    logic [BUFFER_W-1:0]  trig_index_q, trig_index_d;
    logic [TRIGGER_W-1:0] t_prev_q;
    logic [SIGNAL_W-1:0]  rd_data_q;
    logic                 rd_valid_q;

    logic [TRIGGER_W-1:0] t_w, cond_w;
    logic                 fire_w;
    logic                 wr_en_w;
    logic [ROW_W-1:0]     wr_row_w, rd_row_w;
    logic [BUFFER_W-1:0]  rd_addr_w;
    logic [SIGNAL_W-1:0]  rd_sel_w;
    logic                 rd_ok_w;

    logic [ROW_W-1:0] mem [D];

    assign t_w    = trigger_i ^ trigger_negate_i;
    assign cond_w = (trigger_type_i & t_w & ~t_prev_q) | (~trigger_type_i & t_w);

    // Combine enabled trigger conditions (OR or AND); an empty mask never fires
    always_comb begin
        fire_w = 1'b0;
        if (trigger_mask_i != '0) begin
            fire_w = trigger_mode_i ? (&(cond_w | ~trigger_mask_i))
                                    : (|(cond_w & trigger_mask_i));
        end
    end

`ifdef IOB_ILA_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp, advances every enabled cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q <= '0;
        end else if (cke_i) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign wr_row_w = {ts_q, signal_i};
`else
    assign wr_row_w = signal_i;
`endif

    // Capture state machine: arm, pre-trigger fill, post-trigger countdown, abort
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        pre_d        = pre_q;
        post_left_d  = post_left_q;
        start_d      = start_q;
        triggered_d  = triggered_q;
        n_samples_d  = n_samples_q;
        trig_index_d = trig_index_q;
        wr_en_w      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // pretrigger_i is BUFFER_W wide, so it never exceeds D-1
                if (arm_i && !abort_i) begin
                    pre_d        = pretrigger_i;
                    wr_ptr_d     = '0;
                    fill_d       = '0;
                    triggered_d  = 1'b0;
                    n_samples_d  = '0;
                    trig_index_d = '0;
                    state_d      = S_ARMED;
                end
            end
            default: begin
                if (abort_i) begin
                    // Until the buffer has wrapped, the oldest entry is slot 0
                    state_d      = S_DONE;
                    triggered_d  = 1'b0;
                    n_samples_d  = fill_q;
                    trig_index_d = '0;
                    start_d      = (fill_q == FULL) ? wr_ptr_q : '0;
                end else begin
                    wr_en_w  = 1'b1;
                    wr_ptr_d = wr_ptr_q + BUFFER_W'(1);
                    if (fill_q != FULL) begin
                        fill_d = fill_q + (BUFFER_W+1)'(1);
                    end
                    if (state_q == S_ARMED) begin
                        if (fire_w && (fill_q >= {1'b0, pre_q})) begin
                            triggered_d = 1'b1;
                            start_d     = wr_ptr_q - pre_q;
                            post_left_d = ALL_ONE - pre_q;
                            if (pre_q == ALL_ONE) begin
                                state_d      = S_DONE;
                                n_samples_d  = FULL;
                                trig_index_d = pre_q;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end else begin
                        post_left_d = post_left_q - BUFFER_W'(1);
                        if (post_left_q == BUFFER_W'(1)) begin
                            state_d      = S_DONE;
                            n_samples_d  = FULL;
                            trig_index_d = pre_q;
                        end
                    end
                end
            end
        endcase
    end

    // Control registers, frozen while cke_i is low
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            pre_q        <= '0;
            post_left_q  <= '0;
            start_q      <= '0;
            triggered_q  <= 1'b0;
            n_samples_q  <= '0;
            trig_index_q <= '0;
            t_prev_q     <= '0;
        end else if (cke_i) begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            pre_q        <= pre_d;
            post_left_q  <= post_left_d;
            start_q      <= start_d;
            triggered_q  <= triggered_d;
            n_samples_q  <= n_samples_d;
            trig_index_q <= trig_index_d;
            t_prev_q     <= t_w;
        end
    end

    // Sample buffer write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (cke_i && !rst_i && wr_en_w) begin
            mem[wr_ptr_q] <= wr_row_w;
        end
    end

    assign rd_addr_w = start_q + rd_index_i;
    assign rd_row_w  = mem[rd_addr_w];
    assign rd_ok_w   = rd_en_i && (state_q == S_DONE);

    // Channel select; unknown channels read as zero
    always_comb begin
        rd_sel_w = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch_i == 5'(c)) begin
                rd_sel_w = rd_row_w[c*SIGNAL_W +: SIGNAL_W];
            end
        end
`ifdef IOB_ILA_CAPTURE_TIMESTAMP_EN
        if (rd_ch_i == 5'(N_CH)) begin
            rd_sel_w = SIGNAL_W'(rd_row_w[ROW_W-1 -: TS_W]);
        end
`endif
    end

    // Registered read port, one result per enabled cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (cke_i) begin
            rd_valid_q <= rd_ok_w;
            if (rd_ok_w) begin
                rd_data_q <= rd_sel_w;
            end
        end
    end

    assign state_o      = state_q;
    assign triggered_o  = triggered_q;
    assign n_samples_o  = n_samples_q;
    assign trig_index_o = trig_index_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;

endmodule

// File: tb/tb_iob_ila_capture.sv
// Bench for iob_ila_capture with a 16-entry buffer and a 6-bit timestamp.
module tb_iob_ila_capture;
    localparam int N_CH      = 4;
    localparam int SIGNAL_W  = 32;
    localparam int BUFFER_W  = 4;
    localparam int TRIGGER_W = 8;
    localparam int TS_W      = 6;

    logic                     clk = 1'b0;
    logic                     cke_i, rst_i;
    logic [N_CH*SIGNAL_W-1:0] signal_i;
    logic [TRIGGER_W-1:0]     trigger_i, trigger_type_i, trigger_negate_i, trigger_mask_i;
    logic                     trigger_mode_i;
    logic [BUFFER_W-1:0]      pretrigger_i;
    logic                     arm_i, abort_i;
    logic [1:0]               state_o;
    logic                     triggered_o;
    logic [BUFFER_W:0]        n_samples_o;
    logic [BUFFER_W-1:0]      trig_index_o;
    logic                     rd_en_i;
    logic [BUFFER_W-1:0]      rd_index_i;
    logic [4:0]               rd_ch_i;
    logic [SIGNAL_W-1:0]      rd_data_o;
    logic                     rd_valid_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] cnt;
    logic [31:0] exp_q[$];

    iob_ila_capture #(
        .N_CH(N_CH), .SIGNAL_W(SIGNAL_W), .BUFFER_W(BUFFER_W),
        .TRIGGER_W(TRIGGER_W), .TS_W(TS_W)
    ) dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i), .signal_i(signal_i),
        .trigger_i(trigger_i), .trigger_type_i(trigger_type_i),
        .trigger_negate_i(trigger_negate_i), .trigger_mask_i(trigger_mask_i),
        .trigger_mode_i(trigger_mode_i), .pretrigger_i(pretrigger_i),
        .arm_i(arm_i), .abort_i(abort_i), .state_o(state_o),
        .triggered_o(triggered_o), .n_samples_o(n_samples_o),
        .trig_index_o(trig_index_o), .rd_en_i(rd_en_i), .rd_index_i(rd_index_i),
        .rd_ch_i(rd_ch_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_sig();
        signal_i = {cnt ^ 32'hA500_0000, cnt * 32'd3, ~cnt, cnt};
    endtask

    task automatic set_cnt(input logic [31:0] v);
        cnt = v;
        drive_sig();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cnt = cnt + 32'd1;
        drive_sig();
    endtask

    task automatic wait_state(input logic [1:0] s, input int max, output int n);
        n = 0;
        while (state_o !== s && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic arm_at(input logic [31:0] base);
        set_cnt(base);
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
    endtask

    task automatic rd_req(input int idx, input int ch, input logic [31:0] e);
        rd_en_i    = 1'b1;
        rd_index_i = BUFFER_W'(idx);
        rd_ch_i    = 5'(ch);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
        total++; if (triggered_o !== 1'b0) begin bad++; $display("FAIL rst_triggered: got %0b want 0", triggered_o); end
        total++; if (n_samples_o !== '0) begin bad++; $display("FAIL rst_nsamples: got %0d want 0", n_samples_o); end
        total++; if (trig_index_o !== '0) begin bad++; $display("FAIL rst_trigindex: got %0d want 0", trig_index_o); end
        total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rdvalid: got %0b want 0", rd_valid_o); end
        total++; if (rd_data_o !== '0) begin bad++; $display("FAIL rst_rddata: got %0h want 0", rd_data_o); end
    endtask

    task automatic test_level();
        int n;
        logic [31:0] e;
        trigger_mask_i = 8'h01; trigger_type_i = 8'h00; trigger_mode_i = 1'b0;
        pretrigger_i = 4'd4; trigger_i = 8'h00;
        arm_at(32'h15);
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL lvl_armed: got %0d want 1", state_o); end
        repeat (10) step();
        rd_en_i = 1'b1; rd_index_i = '0; rd_ch_i = 5'd0;
        trigger_i = 8'h01;
        step();
        rd_en_i = 1'b0; trigger_i = 8'h00;
        total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL lvl_rd_not_done: got %0b want 0", rd_valid_o); end
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL lvl_post: got %0d want 2", state_o); end
        wait_state(2'd3, 20, n);
        total++; if (n !== 11) begin bad++; $display("FAIL lvl_post_len: got %0d want 11", n); end
        total++; if (triggered_o !== 1'b1) begin bad++; $display("FAIL lvl_triggered: got %0b want 1", triggered_o); end
        total++; if (n_samples_o !== 5'd16) begin bad++; $display("FAIL lvl_nsamples: got %0d want 16", n_samples_o); end
        total++; if (trig_index_o !== 4'd4) begin bad++; $display("FAIL lvl_trigindex: got %0d want 4", trig_index_o); end
        for (int i = 0; i < 20; i++) begin
            if (i < 16)       rd_req(i, 0, 32'h1C + 32'(i));
            else if (i == 16) rd_req(4, 1, ~32'h20);
            else if (i == 17) rd_req(0, 3, 32'h1C ^ 32'hA500_0000);
            else if (i == 18) rd_req(2, N_CH, 32'h0);
            else              rd_req(2, 31, 32'h0);
            step();
            e = exp_q.pop_front();
            total++;
            if (rd_valid_o !== 1'b1) begin bad++; $display("FAIL lvl_rdvalid[%0d]: got %0b want 1", i, rd_valid_o); end
            else if (rd_data_o !== e) begin bad++; $display("FAIL lvl_rddata[%0d]: got %0h want %0h", i, rd_data_o, e); end
        end
        rd_en_i = 1'b0;
        step();
        total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL lvl_rd_idle: got %0b want 0", rd_valid_o); end
    endtask

    task automatic test_pretrigger();
        int n;
        logic [31:0] e;
        trigger_mask_i = 8'h01; trigger_type_i = 8'h00; trigger_mode_i = 1'b0;
        pretrigger_i = 4'd8; trigger_i = 8'h01;
        arm_at(32'h40);
        wait_state(2'd2, 20, n);
        total++; if (n !== 9) begin bad++; $display("FAIL pre_fire_cycle: got %0d want 9", n); end
        trigger_i = 8'h00;
        wait_state(2'd3, 20, n);
        total++; if (n !== 7) begin bad++; $display("FAIL pre_post_len: got %0d want 7", n); end
        total++; if (trig_index_o !== 4'd8) begin bad++; $display("FAIL pre_trigindex: got %0d want 8", trig_index_o); end
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      rd_req(8, 0, 32'h49);
            else if (i == 1) rd_req(0, 0, 32'h41);
            else             rd_req(15, 0, 32'h50);
            step();
            e = exp_q.pop_front();
            total++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== e) begin
                bad++; $display("FAIL pre_rd[%0d]: got %0h (v=%0b) want %0h", i, rd_data_o, rd_valid_o, e);
            end
        end
        rd_en_i = 1'b0;
    endtask

    task automatic test_and_edge();
        int n;
        logic [31:0] trig_val, e;
        trigger_mask_i = 8'h03; trigger_type_i = 8'h01; trigger_mode_i = 1'b1;
        pretrigger_i = 4'd0; trigger_i = 8'h00;
        arm_at(32'h80);
        step();
        trigger_i = 8'h01;
        step();
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL and_rise_bit1_low: got %0d want 1", state_o); end
        trigger_i = 8'h00;
        step();
        trigger_i = 8'h02;
        step();
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL and_level_only: got %0d want 1", state_o); end
        trigger_i = 8'h03;
        trig_val = cnt;
        step();
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL and_fire: got %0d want 2", state_o); end
        trigger_i = 8'h00;
        wait_state(2'd3, 20, n);
        total++; if (n !== 15) begin bad++; $display("FAIL and_post_len: got %0d want 15", n); end
        total++; if (trig_index_o !== 4'd0) begin bad++; $display("FAIL and_trigindex: got %0d want 0", trig_index_o); end
        rd_req(0, 0, trig_val);
        step();
        e = exp_q.pop_front();
        rd_en_i = 1'b0;
        total++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== e) begin
            bad++; $display("FAIL and_trig_sample: got %0h (v=%0b) want %0h", rd_data_o, rd_valid_o, e);
        end
    endtask

    task automatic test_abort();
        logic [31:0] wq[$];
        logic [31:0] e;
        trigger_mask_i = 8'h00; trigger_i = 8'hFF; pretrigger_i = 4'd0;
        arm_at(32'h60);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                cke_i = 1'b0;
                repeat (2) step();
                cke_i = 1'b1;
            end
            wq.push_back(cnt);
            step();
        end
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL abt_armed: got %0d want 1", state_o); end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL abt_done: got %0d want 3", state_o); end
        total++; if (triggered_o !== 1'b0) begin bad++; $display("FAIL abt_triggered: got %0b want 0", triggered_o); end
        total++; if (n_samples_o !== 5'd5) begin bad++; $display("FAIL abt_nsamples: got %0d want 5", n_samples_o); end
        total++; if (trig_index_o !== 4'd0) begin bad++; $display("FAIL abt_trigindex: got %0d want 0", trig_index_o); end
        for (int i = 0; i < 5; i++) begin
            rd_req(i, 0, wq[i]);
            step();
            e = exp_q.pop_front();
            total++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== e) begin
                bad++; $display("FAIL abt_rd[%0d]: got %0h (v=%0b) want %0h", i, rd_data_o, rd_valid_o, e);
            end
        end
        rd_en_i = 1'b0;
        trigger_i = 8'h00;
        arm_i = 1'b1; abort_i = 1'b1;
        step();
        arm_i = 1'b0; abort_i = 1'b0;
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL abt_arm_abort_done: got %0d want 3", state_o); end
    endtask

    task automatic test_precedence();
        int n;
        logic [31:0] e;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        arm_i = 1'b1; abort_i = 1'b1;
        step();
        arm_i = 1'b0; abort_i = 1'b0;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL prec_arm_abort_idle: got %0d want 0", state_o); end
        trigger_mask_i = 8'h01; trigger_type_i = 8'h00; trigger_mode_i = 1'b0;
        pretrigger_i = 4'd0; trigger_i = 8'h01;
        arm_at(32'hA0);
        step();
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL prec_in_post: got %0d want 2", state_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL prec_rst_state: got %0d want 0", state_o); end
        total++; if (n_samples_o !== '0) begin bad++; $display("FAIL prec_rst_nsamples: got %0d want 0", n_samples_o); end
        total++; if (triggered_o !== 1'b0) begin bad++; $display("FAIL prec_rst_triggered: got %0b want 0", triggered_o); end
        pretrigger_i = 4'd15;
        arm_at(32'hC0);
        n = 0;
        while (state_o === 2'd1 && n < 40) begin
            step();
            n++;
        end
        trigger_i = 8'h00;
        total++; if (n !== 16) begin bad++; $display("FAIL prec_pre15_cycles: got %0d want 16", n); end
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL prec_pre15_done: got %0d want 3", state_o); end
        total++; if (n_samples_o !== 5'd16) begin bad++; $display("FAIL prec_pre15_nsamples: got %0d want 16", n_samples_o); end
        total++; if (trig_index_o !== 4'd15) begin bad++; $display("FAIL prec_pre15_trigindex: got %0d want 15", trig_index_o); end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) rd_req(15, 0, 32'hD0);
            else        rd_req(0, 0, 32'hC1);
            step();
            e = exp_q.pop_front();
            total++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== e) begin
                bad++; $display("FAIL prec_pre15_rd[%0d]: got %0h (v=%0b) want %0h", i, rd_data_o, rd_valid_o, e);
            end
        end
        rd_en_i = 1'b0;
    endtask

`ifdef IOB_ILA_CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        int n;
        int runs = 0;
        logic wrap_seen = 1'b0;
        logic [31:0] prev, e;
        trigger_mask_i = 8'h01; trigger_type_i = 8'h00; trigger_mode_i = 1'b0;
        pretrigger_i = 4'd0; trigger_i = 8'h01;
        while (!wrap_seen && runs < 30) begin
            runs++;
            arm_at(cnt);
            wait_state(2'd3, 30, n);
            total++; if (state_o !== 2'd3) begin bad++; $display("FAIL ts_done: got %0d want 3", state_o); end
            prev = 32'h0;
            for (int i = 0; i < 16; i++) begin
                rd_req(i, N_CH, (prev + 32'd1) & 32'h3F);
                step();
                e = exp_q.pop_front();
                if (i > 0) begin
                    total++;
                    if (rd_valid_o !== 1'b1 || rd_data_o !== e) begin
                        bad++; $display("FAIL ts_step[%0d]: got %0h want %0h", i, rd_data_o, e);
                    end
                    if (rd_data_o < prev) wrap_seen = 1'b1;
                end
                prev = rd_data_o;
            end
            rd_en_i = 1'b0;
        end
        trigger_i = 8'h00;
        total++; if (wrap_seen !== 1'b1) begin bad++; $display("FAIL ts_wrap: got %0b want 1", wrap_seen); end
    endtask
`endif

    initial begin
        cke_i = 1'b1; rst_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0;
        trigger_i = '0; trigger_type_i = '0; trigger_negate_i = '0; trigger_mask_i = '0;
        trigger_mode_i = 1'b0; pretrigger_i = '0;
        rd_en_i = 1'b0; rd_index_i = '0; rd_ch_i = '0;
        set_cnt(32'h0);
        test_reset();
        test_level();
        test_pretrigger();
        test_and_edge();
        test_abort();
        test_precedence();
`ifdef IOB_ILA_CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
